// File: rtl/alarm_ring_seq.sv
// Alarm ring sequencer: pulses the buzzer on each alarm event, with bounded snooze and ring timeout.
// Optional: define ALRING_AUTOSNOOZE_EN to turn a ring timeout into an automatic snooze while snoozes remain.
module alarm_ring_seq #(
   parameter int unsigned BEEP_ON_TICKS  = 5,
   parameter int unsigned BEEP_OFF_TICKS = 5,
   parameter int unsigned RING_TIMEOUT   = 600,
   parameter int unsigned SNOOZE_TICKS   = 3000,
   parameter int unsigned MAX_SNOOZE     = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Alarm,
   input  logic       AL_ON,
   input  logic       STOP_al,
   input  logic       SNOOZE,
   output logic       BUZZ,
   output logic       RINGING,
   output logic       SNOOZING,
   output logic [2:0] SNZ_CNT
);

   localparam int unsigned PERIOD = BEEP_ON_TICKS + BEEP_OFF_TICKS;
   localparam int unsigned PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int unsigned RW     = (RING_TIMEOUT > 1) ? $clog2(RING_TIMEOUT) : 1;
   localparam int unsigned SW     = (SNOOZE_TICKS > 1) ? $clog2(SNOOZE_TICKS) : 1;
   localparam logic [2:0]  MAX_SNZ = 3'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RING = 2'd1,
      S_SNZ  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state, state_d;
   logic [RW-1:0] ring_tmr, ring_tmr_d;
   logic [PW-1:0] phase, phase_d;
   logic [SW-1:0] snz_tmr, snz_tmr_d;
   logic [2:0]    snz_cnt_d;
   logic          buzz_d;
   logic          al_q, snz_q;
   logic          al_rise, snz_rise;
   logic          ring_end, snz_end, snz_avail;

   // State, counters, edge-detect history and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ring_tmr <= '0;
         phase    <= '0;
         snz_tmr  <= '0;
         SNZ_CNT  <= '0;
         BUZZ     <= 1'b0;
         RINGING  <= 1'b0;
         SNOOZING <= 1'b0;
         al_q     <= 1'b0;
         snz_q    <= 1'b0;
      end else begin
         state    <= state_d;
         ring_tmr <= ring_tmr_d;
         phase    <= phase_d;
         snz_tmr  <= snz_tmr_d;
         SNZ_CNT  <= snz_cnt_d;
         BUZZ     <= buzz_d;
         RINGING  <= (state_d == S_RING);
         SNOOZING <= (state_d == S_SNZ);
         al_q     <= Alarm;
         snz_q    <= SNOOZE;
      end
   end

   // Next-state, counter and output decode
   always_comb begin
      state_d    = state;
      ring_tmr_d = ring_tmr;
      phase_d    = phase;
      snz_tmr_d  = snz_tmr;
      snz_cnt_d  = SNZ_CNT;
      buzz_d     = 1'b0;
      al_rise    = Alarm & ~al_q;
      snz_rise   = SNOOZE & ~snz_q;
      ring_end   = (ring_tmr == RW'(RING_TIMEOUT - 1));
      snz_end    = (snz_tmr == SW'(SNOOZE_TICKS - 1));
      snz_avail  = (SNZ_CNT < MAX_SNZ);

      case (state)
         S_IDLE: begin
            if (al_rise && AL_ON) begin
               state_d    = S_RING;
               ring_tmr_d = '0;
               phase_d    = '0;
            end
         end
         S_RING: begin
            ring_tmr_d = ring_tmr + 1'b1;
            phase_d    = (phase == PW'(PERIOD - 1)) ? '0 : phase + 1'b1;
            if (!AL_ON) begin
               state_d = S_IDLE;
            end else if (STOP_al) begin
               state_d = S_DONE;
            end else if (ring_end) begin
`ifdef ALRING_AUTOSNOOZE_EN
               if (snz_avail) begin
                  state_d   = S_SNZ;
                  snz_tmr_d = '0;
                  snz_cnt_d = SNZ_CNT + 1'b1;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
            end else if (snz_rise && snz_avail) begin
               state_d   = S_SNZ;
               snz_tmr_d = '0;
               snz_cnt_d = SNZ_CNT + 1'b1;
            end
         end
         S_SNZ: begin
            snz_tmr_d = snz_tmr + 1'b1;
            if (!AL_ON) begin
               state_d = S_IDLE;
            end else if (STOP_al) begin
               state_d = S_DONE;
            end else if (snz_end) begin
               state_d    = S_RING;
               ring_tmr_d = '0;
               phase_d    = '0;
            end
         end
         S_DONE: begin
            if (!AL_ON) begin
               state_d = S_IDLE;
            end else if (STOP_al) begin
               state_d = S_DONE;
            end else if (!Alarm) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Snooze budget is per alarm event
      if (state_d == S_IDLE) snz_cnt_d = '0;
      buzz_d = (state_d == S_RING) && (phase_d < PW'(BEEP_ON_TICKS));
   end

endmodule
